// File: rtl/cache_pkg.sv
// Types and default widths shared by the cache and its write buffer.
package cache_pkg;

  localparam int CACHE_ADDR_W = 10;
  localparam int CACHE_DATA_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic                    valid;
    logic [CACHE_ADDR_W-1:0] addr;
    logic [CACHE_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order store queue with same-address merge; pushes and merges land at the clock edge.
// Full is count-based: the owner must gate push_vld with !full, and a full queue takes no merge either.
module wb_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              push_vld,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              head_busy,
  input  logic              pop,
  input  logic              peek_next,
  output logic [ADDR_W-1:0] peek_addr,
  output logic [DATA_W-1:0] peek_data,
  output logic [CW-1:0]     count,
  output logic              full
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     count_q;
  logic              hit;
  logic [PW-1:0]     hit_idx;
  logic [PW-1:0]     peek_idx;
  logic              push_new;

  // Walk oldest to youngest so the last match wins; the head is skipped once memory owns it.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[head_q + PW'(i)] && (addr_q[head_q + PW'(i)] == push_addr) &&
          !(head_busy && (i == 0))) begin
        hit     = 1'b1;
        hit_idx = head_q + PW'(i);
      end
    end
  end

  assign push_new = push_vld && !hit;
  assign peek_idx = peek_next ? head_q + PW'(1) : head_q;
  assign peek_addr = addr_q[peek_idx];
  // A merge into the entry being loaded this edge must reach memory with the new data.
  assign peek_data = (push_vld && hit && (hit_idx == peek_idx)) ? push_data : data_q[peek_idx];

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push_new) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= push_addr;
        data_q[tail_q]  <= push_data;
        tail_q          <= tail_q + PW'(1);
      end else if (push_vld) begin
        data_q[hit_idx] <= push_data;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      case ({push_new, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/cache_write_buffer.sv
// Absorbs cache word stores and drains them to memory in order, one write per mem_ready pulse.
// First strobe one cycle after the store edge; wr_ready drops while the queue is full.
module cache_write_buffer
  import cache_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              fill_req,
  output logic              empty,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  drain_state_t      state_q;
  drain_state_t      state_nxt;
  logic [CW-1:0]     count;
  logic              full;
  logic              push_vld;
  logic              pop;
  logic              load;
  logic              load_next;
  logic              head_busy;
  logic [ADDR_W-1:0] peek_addr;
  logic [DATA_W-1:0] peek_data;

  assign wr_ready = !full;
  assign push_vld = wr_req && wr_ready;

  wb_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .RST      (RST),
    .push_vld (push_vld),
    .push_addr(wr_addr),
    .push_data(wr_data),
    .head_busy(head_busy),
    .pop      (pop),
    .peek_next(load_next),
    .peek_addr(peek_addr),
    .peek_data(peek_data),
    .count    (count),
    .full     (full)
  );

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_nxt;
  end

  // "Remaining" counts only entries already queued; a store pushed on the last ack drains via IDLE.
  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    load_next = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count != '0) begin
          state_nxt = WRITE;
          load      = 1'b1;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          if (count > CW'(1)) begin
            load      = 1'b1;
            load_next = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    head_busy = (state_q == WRITE);
    mem_we    = (state_q == WRITE);
    pop       = (state_q == WRITE) && mem_ready;
    empty     = (count == '0) && (state_q == IDLE);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (load) begin
      mem_addr  <= peek_addr;
      mem_wdata <= peek_data;
    end
  end

  a_no_store_during_fill: assert property (@(posedge clk) disable iff (!RST) !(fill_req && wr_req));

endmodule
